// File: rtl/sum_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter; each frame is 10 bit periods of CLK_DIV cycles.
// Frames chain back-to-back straight out of STOP whenever bytes are waiting.
module sum_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  // state | meaning
  // IDLE  | line high, waiting for a stored byte
  // START | start bit (low)
  // DATA  | 8 data bits, LSB first
  // STOP  | stop bit (high); pops the next byte at its end if one is waiting
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, bit_end, have_byte;

  // Ready depends on stored count only, so a pop cannot free a slot for a same-edge push.
  assign in_ready  = count_q < CW'(FIFO_DEPTH);
  assign push      = in_valid & in_ready;
  assign have_byte = count_q != '0;
  assign bit_end   = baud_q == '0;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != IDLE && !bit_end) baud_d = baud_q - 16'd1;
    case (state_q)
      IDLE: begin
        if (have_byte) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_LOAD;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_LOAD;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (have_byte) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = BAUD_LOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear keeps the flag set.
    if (in_valid && !in_ready) ovf_d = 1'b1;
    else if (clr_ovf)          ovf_d = 1'b0;
    else                       ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = state_q != IDLE;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: queue/waveform reference model checked every cycle,
// plus directed literal expectations for the headline scenarios.
module tb_sum_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       in_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 1'b0;

  always #5 clk = ~clk;

  sum_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: stored bytes as a queue, the line as a queue of upcoming tx samples.
  logic [7:0] mq[$];
  bit         wq[$];
  bit         m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;

  function automatic void model_edge(input bit v, input logic [7:0] d, input bit c);
    bit         rdy;
    logic [7:0] b;
    int         bitn;
    rdy = mq.size() < DEPTH;
    if (wq.size() == 0 && mq.size() > 0) begin
      b = mq.pop_front();
      for (int k = 0; k < 10 * CLK_DIV; k++) begin
        bitn = k / CLK_DIV;
        wq.push_back(bitn == 0 ? 1'b0 : (bitn == 9 ? 1'b1 : b[bitn-1]));
      end
    end
    if (v && rdy) mq.push_back(d);
    m_busy = wq.size() > 0;
    m_tx   = m_busy ? wq.pop_front() : 1'b1;
    if (v && !rdy) m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      wq.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      model_edge(in_valid, in_data, clr_ovf);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("tx", tx, m_tx);
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, mq.size());
      check("overflow", overflow, m_ovf);
      check("in_ready", in_ready, mq.size() < DEPTH);
    end
  end

  task automatic rx_frame(output logic [7:0] b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_count"}, fifo_count, 3'd0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  logic [7:0] burst [6]      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int         burst_cnt [6]  = '{1, 1, 2, 3, 4, 4};
  bit         a5_bits [8]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int         rnd_pct [6]    = '{3, 20, 60, 95, 40, 10};

  initial begin
    logic [7:0] rb;
    bit         rok;
    bit         exp_tx;

    #1 rst_n = 1'b0;
    #1 reset_checks("por");

    // First push lands on the first edge after release; 0xA5 frame timing.
    @(negedge clk);
    rst_n    = 1'b1;
    cmp_en   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_push_count", fifo_count, 3'd1);
    check("first_push_tx", tx, 1'b1);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 4)       exp_tx = 1'b0;
      else if (k <= 36) exp_tx = a5_bits[(k-5)/4];
      else              exp_tx = 1'b1;
      check("a5_tx", tx, exp_tx);
      check("a5_busy", busy, k <= 40);
    end

    // 0x00 then 0xFF: one contiguous 80-cycle waveform.
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 81; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 80) begin
        exp_tx = (k >= 37 && k <= 40) || k >= 45;
        check("b2b_tx", tx, exp_tx);
        check("b2b_busy", busy, 1'b1);
      end else begin
        check("b2b_end_busy", busy, 1'b0);
      end
    end

    // Six-byte burst into an idle block, overflow clear priority, full FIFO at STOP end.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 5) check("burst_ready_full", in_ready, 1'b0);
          in_valid = 1'b1;
          in_data  = burst[i];
          @(negedge clk);
          check("burst_count", fifo_count, burst_cnt[i]);
        end
        check("burst_ovf", overflow, 1'b1);
        in_data = 8'h99;
        clr_ovf = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", overflow, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 1'b0);
        clr_ovf = 1'b0;
        repeat (33) @(negedge clk);
        check("full_before_pop", fifo_count, 3'd4);
        check("stop_tx", tx, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        check("pop_push_full_count", fifo_count, 3'd3);
        check("pop_push_full_tx", tx, 1'b0);
        check("pop_push_full_ovf", overflow, 1'b1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(rb, rok);
          check("rx_frame_ok", rok, 1'b1);
          check("rx_byte", rb, burst[i]);
        end
      end
    join
    wait_idle("burst_drain_idle", 500);

    // Asynchronous reset in the middle of a frame with bytes queued.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat ($urandom_range(5, 30)) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_reset_push", fifo_count, 3'd1);

    // Randomized traffic at varying load, with one asynchronous reset along the way.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        in_valid = $urandom_range(0, 99) < rnd_pct[blk];
        in_data  = 8'($urandom);
        clr_ovf  = $urandom_range(0, 19) == 0;
        if (blk == 3 && c == 250) begin
          @(posedge clk);
          #3 rst_n = 1'b0;
          #1 reset_checks("rnd_rst");
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    wait_idle("final_drain_idle", 1000);
    check("final_count", fifo_count, 3'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
